// File: rtl/multicycle_datapath.sv
// Multi-cycle R-type datapath: FETCH/DECODE/EXECUTE/WRITEBACK with HALT and a retire strobe.
// Define IMM_OPS_EN to add addi/andi/ori; otherwise those opcodes are flagged illegal.
module multicycle_datapath #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [DATA_W-1:0] Dout,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam int unsigned NumRegs = 2 ** REG_AW;

    typedef enum logic [2:0] {StFetch, StDecode, StExecute, StWriteback, StHalt} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  pc_q;
    logic [31:0]        ir_q;
    logic [DATA_W-1:0]  a_q, b_q, alu_q;
    logic [DATA_W-1:0]  regs_q [NumRegs];

    logic [5:0]         op, funct;
    logic [REG_AW-1:0]  rs, rt, rd, dest;
    logic [DATA_W-1:0]  rf_a, rf_b, alu_res;
    logic               supported, reg_we;
    logic               unused_ir;

    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign rs        = ir_q[21 +: REG_AW];
    assign rt        = ir_q[16 +: REG_AW];
    assign rd        = ir_q[11 +: REG_AW];
    assign unused_ir = ^ir_q;

    // R0 is never stored; reads of it are forced to zero.
    assign rf_a = (rs == '0) ? '0 : regs_q[rs];
    assign rf_b = (rt == '0) ? '0 : regs_q[rt];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:     state_d = StDecode;
            StDecode:    state_d = (ir_q == 32'hFFFF_FFFF) ? StHalt : StExecute;
            StExecute:   state_d = StWriteback;
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StFetch;
        endcase
    end

    // Decode and ALU; IR stays stable from DECODE through WRITEBACK.
    always_comb begin
        alu_res   = '0;
        supported = 1'b0;
        dest      = rd;
        case (op)
            6'h00: begin
                supported = 1'b1;
                case (funct)
                    6'h20:   alu_res = a_q + b_q;
                    6'h22:   alu_res = a_q - b_q;
                    6'h24:   alu_res = a_q & b_q;
                    6'h25:   alu_res = a_q | b_q;
                    6'h26:   alu_res = a_q ^ b_q;
                    6'h27:   alu_res = ~(a_q | b_q);
                    6'h2A:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
                    default: supported = 1'b0;
                endcase
            end
`ifdef IMM_OPS_EN
            6'h08: begin
                supported = 1'b1;
                dest      = rt;
                alu_res   = a_q + DATA_W'($signed(ir_q[15:0]));
            end
            6'h0C: begin
                supported = 1'b1;
                dest      = rt;
                alu_res   = a_q & DATA_W'(ir_q[15:0]);
            end
            6'h0D: begin
                supported = 1'b1;
                dest      = rt;
                alu_res   = a_q | DATA_W'(ir_q[15:0]);
            end
`endif
            default: supported = 1'b0;
        endcase
    end

    assign reg_we = (state_q == StWriteback) && supported && (dest != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StFetch:     ir_q <= imem_rdata;
                StDecode: begin
                    a_q <= rf_a;
                    b_q <= rf_b;
                end
                StExecute:   alu_q <= alu_res;
                StWriteback: pc_q <= pc_q + DATA_W'(PC_STEP);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[dest] <= alu_q;
        end
    end

    assign imem_addr = pc_q;
    assign Dout      = alu_q;
    assign retire    = (state_q == StWriteback);
    assign halted    = (state_q == StHalt);
    assign illegal   = retire && !supported && !unused_ir_dummy();

    function automatic logic unused_ir_dummy();
        return 1'b0;
    endfunction

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: table-driven program with a retire scoreboard,
// reset-abort and halt sequences, and a 16-bit instance that walks the PC through its wrap.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset, rst16;
    logic [31:0] imem_addr, imem_rdata, dout;
    logic        retire, halted, illegal;
    logic [15:0] imem_addr16, dout16;
    logic        retire16, halted16, illegal16;

    always #5 clk = ~clk;

`ifdef IMM_OPS_EN
    localparam bit Imm = 1'b1;
`else
    localparam bit Imm = 1'b0;
`endif

    logic [31:0] imem [64];
    assign imem_rdata = (imem_addr < 32'd256) ? imem[imem_addr[7:2]] : 32'hFFFF_FFFF;

    multicycle_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .Dout       (dout),
        .retire     (retire),
        .halted     (halted),
        .illegal    (illegal)
    );

    // Every word is add r0,r0,r0, so only the PC moves.
    multicycle_datapath #(.DATA_W(16)) dut16 (
        .clk        (clk),
        .reset      (rst16),
        .imem_addr  (imem_addr16),
        .imem_rdata (32'h0000_0020),
        .Dout       (dout16),
        .retire     (retire16),
        .halted     (halted16),
        .illegal    (illegal16)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] dout;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        ill;
        logic [31:0] addr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25;
    localparam logic [5:0] FnXor = 6'h26, FnNor = 6'h27, FnSlt = 6'h2A;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic add(logic [31:0] instr, logic [31:0] d, logic ill);
        vec_t v;
        v.instr = instr;
        v.dout  = d;
        v.ill   = ill;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_retire(input bit narrow, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n++;
            if (narrow ? retire16 : retire) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_main();
        int n;
        bit ok;
        exp_t e;
        // Abort an instruction mid-EXECUTE: its write to r9 must never happen.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pc", imem_addr, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_retire", {31'd0, retire}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);

        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
        foreach (vecs[i]) begin
            imem[i] = vecs[i].instr;
            e.dout  = vecs[i].dout;
            e.ill   = vecs[i].ill;
            e.addr  = 32'(i * 4);
            sb.push_back(e);
        end
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            wait_retire(1'b0, n, ok);
            if (!ok) begin
                check($sformatf("retire_timeout_%0d", i), 32'd0, 32'd1);
                return;
            end
            e = sb.pop_front();
            check($sformatf("dout_%0d", i), dout, e.dout);
            check($sformatf("illegal_%0d", i), {31'd0, illegal}, {31'd0, e.ill});
            check($sformatf("pc_%0d", i), imem_addr, e.addr);
            check($sformatf("spacing_%0d", i), n, (i == 0) ? 3 : 4);
        end

        n  = 0;
        ok = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        check("halted", {31'd0, ok}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("halt_pc_%0d", c), imem_addr, 32'(vecs.size() * 4));
            check($sformatf("halt_quiet_%0d", c), {29'd0, halted, retire, illegal}, 32'd4);
        end
    endtask

    task automatic run_wrap();
        int n;
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (imem_addr16 == 16'hFFFC) begin
                ok = 1'b1;
                break;
            end
        end
        check("wrap_reached_top", {31'd0, ok}, 32'd1);
        if (!ok) return;
        wait_retire(1'b1, n, ok);
        check("wrap_retire_top", {31'd0, ok}, 32'd1);
        check("wrap_pc_top", {16'd0, imem_addr16}, 32'h0000_FFFC);
        @(negedge clk);
        check("wrap_pc_zero", {16'd0, imem_addr16}, 32'd0);
        wait_retire(1'b1, n, ok);
        check("wrap_no_stall", n, 3);
        check("wrap_retire_zero", {16'd0, imem_addr16}, 32'd0);
    endtask

    initial begin
        add(rtype(0, 0, 1, FnNor), 32'hFFFF_FFFF, 1'b0);  // r1 = -1
        add(rtype(0, 1, 2, FnSub), 32'd1, 1'b0);          // r2 = 1
        add(rtype(2, 2, 3, FnAdd), 32'd2, 1'b0);          // r3 = 2
        add(rtype(3, 3, 4, FnAdd), 32'd4, 1'b0);          // r4 = 4
        add(rtype(4, 2, 1, FnAdd), 32'd5, 1'b0);          // r1 = 5
        add(rtype(1, 3, 2, FnAdd), 32'd7, 1'b0);          // r2 = 7
        add(rtype(1, 2, 3, FnAdd), 32'd12, 1'b0);         // add r3,r1,r2
        add(rtype(1, 2, 4, FnSub), 32'hFFFF_FFFE, 1'b0);  // sub r4,r1,r2
        add(rtype(4, 1, 5, FnSlt), 32'd1, 1'b0);          // slt r5,r4,r1 (signed)
        add(rtype(1, 2, 0, FnAdd), 32'd12, 1'b0);         // add r0 discarded
        add(rtype(0, 2, 8, FnAdd), 32'd7, 1'b0);          // r0 reads 0
        add(rtype(9, 0, 10, FnOr), 32'd0, 1'b0);          // r9 untouched by aborted op
        add(rtype(1, 2, 11, FnAnd), 32'd5, 1'b0);
        add(rtype(1, 2, 12, FnXor), 32'd2, 1'b0);
        add(rtype(1, 4, 13, FnSlt), 32'd0, 1'b0);
        add(rtype(1, 4, 14, FnAnd), 32'd4, 1'b0);
        add(rtype(1, 2, 15, 6'h3F), 32'd0, 1'b1);         // unsupported funct
        add(rtype(15, 1, 16, FnOr), 32'd5, 1'b0);         // r15 stayed 0
        add(itype(6'h08, 0, 6, 16'hFFFF), Imm ? 32'hFFFF_FFFF : 32'd0, !Imm);
        add(itype(6'h0D, 0, 7, 16'h8000), Imm ? 32'h0000_8000 : 32'd0, !Imm);
        add(rtype(6, 0, 17, FnOr), Imm ? 32'hFFFF_FFFF : 32'd0, 1'b0);
        add(rtype(7, 0, 18, FnOr), Imm ? 32'h0000_8000 : 32'd0, 1'b0);

        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
        imem[0] = rtype(0, 0, 9, FnNor);
        reset   = 1'b1;
        rst16   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rst16 = 1'b0;
        fork
            run_main();
            run_wrap();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
